pipeline_result_fifo: RTL and testbench

//  Downstream stage of the arithmetic pipeline F = (A+B+C-D)*D. Tracks which launches carry real

---
 rtl/pipeline_result_fifo.sv | 92 +++++++++
 tb/tb_pipeline_result_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_result_fifo.sv
// Result capture stage for F = (A+B+C-D)*D: a valid-tag delay line matched to pipeline
// latency feeds a first-word fall-through FIFO with a valid/ready output and sticky drop flag.
module pipeline_result_fifo #(
    parameter int N     = 10,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    input  logic [N-1:0]               f_in,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [N-1:0]               m_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [LAT-1:0] tag;
    logic [N-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           full;
    logic           push_ok;
    logic           drop;

    assign push    = tag[LAT-1];
    assign pop     = m_valid & m_ready;
    assign full    = (count == CW'(DEPTH));
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else begin
            tag[0] <= op_valid;
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= f_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Bench for pipeline_result_fifo: emulates the arithmetic pipeline on f_in and checks the
// output port every cycle against a queue-based model of tagged results.
module tb_pipeline_result_fifo;
    localparam int N     = 10;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic [N-1:0]  f_in;
    logic          m_ready;
    logic          m_valid;
    logic [N-1:0]  m_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_ovf;

    pipeline_result_fifo #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .f_in       (f_in),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [N-1:0] f;
    } flight_t;

    int           checks;
    int           failures;
    int           cyc;
    logic [N-1:0] model_q[$];
    bit           model_ovf;
    flight_t      inflight[$];
    logic [N-1:0] fsr[LAT];
    logic [N-1:0] got[$];
    logic [N-1:0] sent[$];

    function automatic logic [N-1:0] calc_f(input int a, input int b, input int c, input int d);
        int r;
        r = (a + b + c - d) * d;
        return r[N-1:0];
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance model and pipeline.
    task automatic drive_cycle(input bit v, input int a, input int b, input int c, input int d,
                               input bit rdy, input bit clr);
        logic [N-1:0] f;
        logic [N-1:0] exp_data;
        bit           exp_valid;
        bit           push;
        bit           pop;
        bit           full;
        f        = calc_f(a, b, c, d);
        op_valid = v;
        m_ready  = rdy;
        clr_ovf  = clr;
        exp_valid = (model_q.size() != 0);
        exp_data  = exp_valid ? model_q[0] : '0;
        checks += 4;
        if (m_valid !== exp_valid) begin
            failures++;
            $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_valid);
        end
        if (m_data !== exp_data) begin
            failures++;
            $display("FAIL m_data cyc=%0d got=%0d exp=%0d", cyc, m_data, exp_data);
        end
        if (fifo_count !== CW'(model_q.size())) begin
            failures++;
            $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, model_q.size());
        end
        if (overflow !== model_ovf) begin
            failures++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, model_ovf);
        end
        if (m_valid && rdy) got.push_back(m_data);
        if (v) begin
            inflight.push_back('{cyc + LAT, f});
            sent.push_back(f);
        end
        push = (inflight.size() != 0) && (inflight[0].due == cyc);
        pop  = exp_valid && rdy;
        full = (model_q.size() == DEPTH);
        if (pop) void'(model_q.pop_front());
        if (push) begin
            if (!full || pop) model_q.push_back(inflight[0].f);
            void'(inflight.pop_front());
        end
        if (push && full && !pop) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) fsr[i] = fsr[i-1];
        fsr[0] = f;
        f_in   = fsr[LAT-1];
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic rand_launch(input bit v, input bit rdy, input bit clr);
        drive_cycle(v, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), rdy, clr);
    endtask

    task automatic test_reset();
        checks += 3;
        if (m_valid !== 1'b0 || m_data !== '0) begin
            failures++;
            $display("FAIL reset_out got valid=%b data=%0d exp valid=0 data=0", m_valid, m_data);
        end
        if (fifo_count !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", fifo_count);
        end
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", overflow);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        drive_cycle(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        drive_cycle(1'b1, 0, 3, 5, 2, 1'b1, 1'b0);
        #2;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        inflight.delete();
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        checks += 2;
        if (m_valid !== 1'b0 || fifo_count !== '0) begin
            failures++;
            $display("FAIL reset_mid got valid=%b count=%0d exp valid=0 count=0", m_valid, fifo_count);
        end
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ovf got=%b exp=0", overflow);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 3;
        idle(LAT + 3);
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL reset_late_capture got=%0d results exp=0", got.size());
        end
    endtask

    task automatic test_sequence();
        int           start;
        int           first;
        logic [N-1:0] exp4[4];
        exp4 = '{10'd8, 10'd12, 10'd1, 10'd8};
        got.delete();
        start = cyc;
        first = -1;
        drive_cycle(1'b1, 1, 2, 3, 4, 1'b1, 1'b0);
        drive_cycle(1'b1, 0, 3, 5, 2, 1'b1, 1'b0);
        drive_cycle(1'b1, 1, 0, 1, 1, 1'b1, 1'b0);
        drive_cycle(1'b1, 2, 2, 2, 2, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (m_valid === 1'b1 && first < 0) first = cyc - start;
            idle(1);
        end
        checks += 2;
        if (first != LAT + 1) begin
            failures++;
            $display("FAIL seq_latency got=%0d exp=%0d", first, LAT + 1);
        end
        if (got.size() != 4) begin
            failures++;
            $display("FAIL seq_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp4[i]) begin
                    failures++;
                    $display("FAIL seq_value[%0d] got=%0d exp=%0d", i, got[i], exp4[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        got.delete();
        sent.delete();
        for (int i = 0; i < 12; i++) rand_launch(i % 2 == 0, 1'b1, 1'b0);
        idle(LAT + 2);
        checks++;
        if (got.size() != 6) begin
            failures++;
            $display("FAIL gaps_count got=%0d exp=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL gaps_value[%0d] got=%0d exp=%0d", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        got.delete();
        sent.delete();
        for (int i = 0; i < DEPTH; i++) rand_launch(1'b1, 1'b0, 1'b0);
        rand_launch(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) drive_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        checks += 2;
        if (fifo_count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=%0d", fifo_count, DEPTH);
        end
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL stall_ovf_drop_vs_clear got=%b exp=1", overflow);
        end
        drive_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(DEPTH + 1);
        checks++;
        if (got.size() != DEPTH) begin
            failures++;
            $display("FAIL stall_drain_count got=%0d exp=%0d", got.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL stall_value[%0d] got=%0d exp=%0d", i, got[i], sent[i]);
                end
            end
        end
        drive_cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL stall_clr_ovf got=%b exp=0", overflow);
        end
        idle(1);
    endtask

    task automatic test_full_pushpop();
        int total;
        got.delete();
        sent.delete();
        total = DEPTH + LAT + 6;
        for (int i = 0; i < total; i++) begin
            if (i > DEPTH + LAT) begin
                checks += 2;
                if (fifo_count !== CW'(DEPTH)) begin
                    failures++;
                    $display("FAIL full_pp_count i=%0d got=%0d exp=%0d", i, fifo_count, DEPTH);
                end
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL full_pp_ovf i=%0d got=%b exp=0", i, overflow);
                end
            end
            rand_launch(1'b1, i >= DEPTH + LAT, 1'b0);
        end
        idle(LAT + DEPTH + 2);
        checks++;
        if (got.size() != total) begin
            failures++;
            $display("FAIL full_pp_total got=%0d exp=%0d", got.size(), total);
        end else begin
            for (int i = 0; i < total; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL full_pp_value[%0d] got=%0d exp=%0d", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit           prev_stall;
        logic [N-1:0] prev_data;
        bit           rdy;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 200; i++) begin
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got valid=%b data=%0d exp valid=1 data=%0d",
                             cyc, m_valid, m_data, prev_data);
                end
            end
            rdy        = ($urandom_range(0, 2) != 0);
            prev_stall = (m_valid === 1'b1) && !rdy;
            prev_data  = m_data;
            rand_launch($urandom_range(0, 3) != 0, rdy, $urandom_range(0, 15) == 0);
        end
        idle(LAT + DEPTH + 2);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        model_ovf = 1'b0;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        m_ready   = 1'b0;
        clr_ovf   = 1'b0;
        f_in      = '0;
        for (int i = 0; i < LAT; i++) fsr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sequence();
        test_gaps();
        test_stall();
        test_full_pushpop();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
